// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer: drives a shared combinational ALU with ADD/SLL/SRL
// and returns the low WIDTH bits of a*b.
module alu_mul_seq #(
  parameter int         WIDTH      = 32,
  parameter bit         EARLY_EXIT = 1'b1,
  parameter logic [3:0] OP_ADD     = 4'b0000,
  parameter logic [3:0] OP_SLL     = 4'b0110,
  parameter logic [3:0] OP_SRL     = 4'b0111
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_sol,
  input  logic             alu_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // ADD   | acc <= acc + mc
  // SHL   | mc  <= mc << 1
  // SHR   | mp  <= mp >> 1, count bit, decide exit
  // DONE  | product valid, done pulse; accepts a new start
  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp, r_product;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mc      <= '0;
      r_mp      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_acc  <= '0;
            r_mc   <= a;
            r_mp   <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            // A zero multiplier passes through SHR once so done lands one edge later
            if (EARLY_EXIT && (b == '0)) r_state <= S_SHR;
            else if (b[0])               r_state <= S_ADD;
            else                         r_state <= S_SHL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          r_acc   <= alu_sol;
          r_state <= S_SHL;
        end
        S_SHL: begin
          r_mc    <= alu_sol;
          r_state <= S_SHR;
        end
        S_SHR: begin
          r_mp  <= alu_sol;
          r_cnt <= r_cnt + 1'b1;
          if ((EARLY_EXIT && alu_zero) || (r_cnt == LAST)) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_product <= r_acc;
          end else if (alu_sol[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SHL;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ALU drive depends only on state and registers
  always_comb begin
    alu_op  = OP_ADD;
    alu_op1 = '0;
    alu_op2 = '0;
    case (r_state)
      S_ADD: begin
        alu_op  = OP_ADD;
        alu_op1 = r_acc;
        alu_op2 = r_mc;
      end
      S_SHL: begin
        alu_op  = OP_SLL;
        alu_op1 = r_mc;
        alu_op2 = WIDTH'(1);
      end
      S_SHR: begin
        alu_op  = OP_SRL;
        alu_op1 = r_mp;
        alu_op2 = WIDTH'(1);
      end
      default: begin
        alu_op  = OP_ADD;
        alu_op1 = '0;
        alu_op2 = '0;
      end
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU and hand-computed results.
module tb_alu_mul_seq;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] product;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1, alu_op2, alu_sol;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;

  alu_mul_seq dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sol(alu_sol), .alu_zero(alu_zero)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    alu_sol = 32'h0;
    case (alu_op)
      4'b0000: alu_sol = alu_op1 + alu_op2;
      4'b0110: alu_sol = alu_op1 << alu_op2[4:0];
      4'b0111: alu_sol = alu_op1 >> alu_op2[4:0];
      default: alu_sol = 32'h0;
    endcase
  end
  assign alu_zero = (alu_sol == 32'h0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a multiply at the next edge, records the ALU op stream and measures latency.
  task automatic run_mul(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] exp_p, input int exp_n, input int pulse_at,
                         output logic [31:0] seq, output int adds);
    int   n;
    logic got, busy_ok;
    a = ia; b = ib; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    n = 0; got = 1'b0; busy_ok = 1'b1; seq = 32'h0; adds = 0;
    seq = {seq[27:0], alu_op};
    if (alu_op == 4'b0000) adds++;
    if (!busy) busy_ok = 1'b0;
    while (!got && n < 400) begin
      @(posedge CLK); #1;
      n++;
      if (done) got = 1'b1;
      else begin
        seq = {seq[27:0], alu_op};
        if (alu_op == 4'b0000) adds++;
        if (!busy) busy_ok = 1'b0;
        if (n == pulse_at) begin
          start = 1'b1; a = 32'd99; b = 32'd77;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'h0, got}, 32'h1);
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_busy_while_running"}, {31'h0, busy_ok}, 32'h1);
    chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
  endtask

  logic [31:0] seq;
  int          adds;
  int          dcnt;

  initial begin
    RST_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_product", product, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_alu_op1", alu_op1, 32'h0);
    chk("rst_alu_op2", alu_op2, 32'h0);
    RST_n = 1'b1;
    @(negedge CLK);

    run_mul("t2_7x5", 32'd7, 32'd5, 32'd35, 8, -1, seq, adds);
    chk("t2_op_seq", seq, 32'h0676_7067);

    run_mul("t3_b0", 32'h1234, 32'h0, 32'h0, 1, -1, seq, adds);
    chk("t3_no_add", adds, 0);

    run_mul("t4_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 96, -1, seq, adds);

    run_mul("t5_neg3x6", 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFEE, 8, -1, seq, adds);

    run_mul("t6_midop_start", 32'd3, 32'd4, 32'd12, 7, 3, seq, adds);

    // reset asserted four edges into a 7x5 run
    a = 32'd7; b = 32'd5; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("t6_pre_rst_busy", {31'h0, busy}, 32'h1);
    RST_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_done", {31'h0, done}, 32'h0);
    chk("t6_rst_product", product, 32'h0);
    chk("t6_rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("t6_rst_alu_op1", alu_op1, 32'h0);
    chk("t6_rst_alu_op2", alu_op2, 32'h0);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (done) dcnt++;
    end
    chk("t6_no_done_after_rst", dcnt, 0);

    // back-to-back: second start is driven during the DONE cycle of the first
    run_mul("t6_b2b_first", 32'd7, 32'd5, 32'd35, 8, -1, seq, adds);
    run_mul("t6_b2b_second", 32'd6, 32'd3, 32'd18, 6, -1, seq, adds);
    @(posedge CLK); #1;
    chk("t6_done_one_cycle", {31'h0, done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
